// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Brief    : Request/response bundle between the pipeline stages and the
//            stall/flush scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              inst_stall_req;
    logic              id_stall_req;
    logic              exe_stall_req;
    logic              data_stall_req;
    logic              inst_busy;
    logic              excep_valid;
    logic [ADDR_W-1:0] excep_target;
    logic              perf_clr;

    logic [3:0]        stall;
    logic              exception;
    logic              discard_fetch;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  stall_cycles;

    // Pipeline side: raises requests, consumes stall/flush controls
    modport master (
        output inst_stall_req, id_stall_req, exe_stall_req, data_stall_req,
        output inst_busy, excep_valid, excep_target, perf_clr,
        input  stall, exception, discard_fetch, redirect_valid, redirect_pc,
        input  stall_cycles
    );

    // Scheduler side
    modport slave (
        input  inst_stall_req, id_stall_req, exe_stall_req, data_stall_req,
        input  inst_busy, excep_valid, excep_target, perf_clr,
        output stall, exception, discard_fetch, redirect_valid, redirect_pc,
        output stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall merge, exception flush sequencing and stall-cycle counter
//            for the 5-stage pipeline. All outputs registered.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pipeline_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        REDIRECT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_stall;
    logic [3:0]        w_stall_nxt;
    logic              r_exception;
    logic              w_exception_nxt;
    logic              r_discard;
    logic              w_discard_nxt;
    logic              r_redirect_valid;
    logic              w_redirect_valid_nxt;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic [ADDR_W-1:0] w_redirect_pc_nxt;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic              w_accept;

    // A data access in flight must complete before the exception can commit
    assign w_accept = bus.excep_valid && !bus.data_stall_req;

    always_comb begin
        w_state_nxt          = r_state;
        w_stall_nxt          = 4'b0000;
        w_exception_nxt      = 1'b0;
        w_discard_nxt        = 1'b0;
        w_redirect_valid_nxt = 1'b0;
        w_redirect_pc_nxt    = r_redirect_pc;
        case (r_state)
            RUN: begin
                if (w_accept) begin
                    w_exception_nxt   = 1'b1;
                    w_redirect_pc_nxt = bus.excep_target;
                    w_state_nxt       = bus.inst_busy ? FLUSH_WAIT : REDIRECT;
                end else if (bus.data_stall_req) begin
                    w_stall_nxt = 4'b1111;
                end else if (bus.exe_stall_req) begin
                    w_stall_nxt = 4'b0111;
                end else if (bus.id_stall_req) begin
                    w_stall_nxt = 4'b0011;
                end else if (bus.inst_stall_req) begin
                    w_stall_nxt = 4'b0001;
                end
            end
            FLUSH_WAIT: begin
                if (bus.inst_busy) begin
                    w_stall_nxt   = 4'b0001;
                    w_discard_nxt = 1'b1;
                end else begin
                    w_state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                w_redirect_valid_nxt = 1'b1;
                w_state_nxt          = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= RUN;
            r_stall          <= 4'b0000;
            r_exception      <= 1'b0;
            r_discard        <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_stall          <= w_stall_nxt;
            r_exception      <= w_exception_nxt;
            r_discard        <= w_discard_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
        end
    end

    // Counts cycles in which the issued stall vector is non-zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (bus.perf_clr) begin
            r_stall_cycles <= '0;
        end else if ((r_stall != 4'b0000) && (r_stall_cycles != C_CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign bus.stall          = r_stall;
    assign bus.exception      = r_exception;
    assign bus.discard_fetch  = r_discard;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.stall_cycles   = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed and randomized checks of pipeline_ctrl against a
//            cycle-level behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 4;
    localparam int C_CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipeline_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = normal, 1 = flushing while fetch drains,
    // 2 = fetch drained, redirect due at the next edge
    int          m_phase;
    logic [3:0]  m_stall;
    logic        m_exc;
    logic        m_disc;
    logic        m_rv;
    logic [31:0] m_pc;
    int          m_cnt;

    function automatic logic [3:0] stall_mask(input logic [3:0] req);
        logic [4:0] t;
        t = 5'd0;
        for (int i = 0; i < 4; i++)
            if (req[i]) t = (5'd1 << (i + 1)) - 5'd1;
        return t[3:0];
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_stall = 4'b0;
        m_exc   = 1'b0;
        m_disc  = 1'b0;
        m_rv    = 1'b0;
        m_pc    = 32'h0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        logic [3:0] req;
        req = {bus.data_stall_req, bus.exe_stall_req, bus.id_stall_req, bus.inst_stall_req};
        if (bus.perf_clr)            m_cnt = 0;
        else if (m_stall != 4'b0000) m_cnt = (m_cnt < C_CNT_MAX) ? m_cnt + 1 : C_CNT_MAX;
        m_stall = 4'b0;
        m_exc   = 1'b0;
        m_disc  = 1'b0;
        m_rv    = 1'b0;
        if (m_phase == 0) begin
            if (bus.excep_valid && !bus.data_stall_req) begin
                m_exc   = 1'b1;
                m_pc    = bus.excep_target;
                m_phase = bus.inst_busy ? 1 : 2;
            end else begin
                m_stall = stall_mask(req);
            end
        end else if (m_phase == 1) begin
            if (bus.inst_busy) begin
                m_stall = 4'b0001;
                m_disc  = 1'b1;
            end else begin
                m_phase = 2;
            end
        end else begin
            m_rv    = 1'b1;
            m_phase = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("stall",          {28'h0, bus.stall},          {28'h0, m_stall});
        chk("exception",      {31'h0, bus.exception},      {31'h0, m_exc});
        chk("discard_fetch",  {31'h0, bus.discard_fetch},  {31'h0, m_disc});
        chk("redirect_valid", {31'h0, bus.redirect_valid}, {31'h0, m_rv});
        chk("redirect_pc",    bus.redirect_pc,             m_pc);
        chk("stall_cycles",   {28'h0, bus.stall_cycles},   m_cnt[31:0]);
    endtask

    // req bits: [0]=inst [1]=id [2]=exe [3]=data
    task automatic step(input logic [3:0] req, input logic ev, input logic [31:0] tgt,
                        input logic busy, input logic clr);
        bus.inst_stall_req = req[0];
        bus.id_stall_req   = req[1];
        bus.exe_stall_req  = req[2];
        bus.data_stall_req = req[3];
        bus.excep_valid    = ev;
        bus.excep_target   = tgt;
        bus.inst_busy      = busy;
        bus.perf_clr       = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.inst_stall_req = 1'b0;
        bus.id_stall_req   = 1'b0;
        bus.exe_stall_req  = 1'b0;
        bus.data_stall_req = 1'b0;
        bus.excep_valid    = 1'b0;
        bus.excep_target   = 32'h0;
        bus.inst_busy      = 1'b0;
        bus.perf_clr       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Quiet pipeline
        idle(10);

        // Two simultaneous requests: execute wins, one stalled cycle counted
        step(4'b0110, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_id_exe", {28'h0, bus.stall}, 32'h7);
        idle(2);
        chk("cnt_after_one", {28'h0, bus.stall_cycles}, 32'h1);

        // Exception with fetch idle
        step(4'b0000, 1'b1, 32'hBFC00380, 1'b0, 1'b0);
        chk("exc_pulse", {31'h0, bus.exception}, 32'h1);
        idle(1);
        chk("redir_fast", {31'h0, bus.redirect_valid}, 32'h1);
        chk("redir_pc_fast", bus.redirect_pc, 32'hBFC00380);
        idle(2);

        // Exception with an instruction fetch outstanding for 3 more cycles
        step(4'b0010, 1'b1, 32'h80000180, 1'b1, 1'b0);
        chk("exc_busy", {31'h0, bus.exception}, 32'h1);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("flush_stall", {28'h0, bus.stall}, 32'h1);
        chk("flush_discard", {31'h0, bus.discard_fetch}, 32'h1);
        idle(2);
        chk("redir_slow_pc", bus.redirect_pc, 32'h80000180);
        idle(1);

        // Exception deferred behind a data access
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b1, 32'hBFC00200, 1'b0, 1'b0);
        chk("deferred_stall", {28'h0, bus.stall}, 32'hF);
        chk("deferred_noexc", {31'h0, bus.exception}, 32'h0);
        step(4'b0000, 1'b1, 32'hBFC00200, 1'b0, 1'b0);
        chk("deferred_exc", {31'h0, bus.exception}, 32'h1);
        idle(3);

        // Counter saturation, then clear
        for (int i = 0; i < 20; i++) step(4'b1000, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1);
        chk("cnt_saturated", {28'h0, bus.stall_cycles}, 32'hF);
        step(4'b1000, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("cnt_cleared", {28'h0, bus.stall_cycles}, 32'h0);
        idle(2);

        // Asynchronous reset in the middle of a fetch drain
        step(4'b0000, 1'b1, 32'h12345678, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] req;
            req[0] = ($urandom_range(0, 2) == 0);
            req[1] = ($urandom_range(0, 3) == 0);
            req[2] = ($urandom_range(0, 4) == 0);
            req[3] = ($urandom_range(0, 4) == 0);
            step(req, ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 31) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
